// File: rtl/lamp_safety_monitor.sv
// Safety monitor between a traffic light controller and the lamp drivers: decodes signal codes,
// latches conflict / illegal-transition faults and flashes yellow until a held all-red clear.
module lamp_safety_monitor #(
   parameter int unsigned FLASH_HALF = 5,
   parameter int unsigned CLR_HOLD   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] h1,
   input  logic [1:0] h2,
   input  logic [1:0] f1,
   input  logic [1:0] f2,
   input  logic       clr,
   output logic [2:0] h1_lamp,
   output logic [2:0] h2_lamp,
   output logic [2:0] f1_lamp,
   output logic [2:0] f2_lamp,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic       flash
);

   localparam int unsigned CW = $clog2(FLASH_HALF) + 1;
   localparam int unsigned HW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD + 1) : 1;
   localparam logic [1:0] RED = 2'b10;

   typedef enum logic [1:0] {StNormal, StFlash, StRecover} state_e;

   state_e          state_q, state_d;
   logic [3:0][1:0] cur;
   logic [3:0][1:0] prev_q, prev_d;
   logic            prev_vld_q, prev_vld_d;
   logic [3:0][2:0] lamp_q, lamp_d;
   logic [1:0]      code_q, code_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            on_q, on_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            conflict, illegal, all_red, hold_done, violation;

   function automatic logic [2:0] decode(input logic [1:0] c);
      logic [2:0] l;
      unique case (c)
         2'b00:   l = 3'b001;
         2'b01:   l = 3'b010;
         2'b10:   l = 3'b100;
         default: l = 3'b110;
      endcase
      return l;
   endfunction

   function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
      return (p == c) || (p == 2'b10 && c == 2'b11) || (p == 2'b11 && c == 2'b00) ||
             (p == 2'b00 && c == 2'b01) || (p == 2'b01 && c == 2'b10);
   endfunction

   assign cur = {h1, h2, f1, f2};

   always_comb begin
      conflict = (h1 != RED || h2 != RED) && (f1 != RED || f2 != RED);
      illegal  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (prev_vld_q && !legal_step(prev_q[i], cur[i])) illegal = 1'b1;
      end
      violation = conflict || illegal;
      all_red   = (cur == {4{RED}});
      hold_done = (hold_q == HW'(CLR_HOLD - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StNormal;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StNormal:  if (violation) state_d = StFlash;
         StFlash:   if (clr && all_red) state_d = StRecover;
         StRecover: begin
            if (!all_red)      state_d = StFlash;
            else if (hold_done) state_d = StNormal;
         end
         default:   state_d = StNormal;
      endcase
   end

   // Datapath next values
   always_comb begin
      lamp_d     = lamp_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      code_d     = code_q;
      cnt_d      = cnt_q;
      on_d       = on_q;
      hold_d     = hold_q;
      // Blink phase runs through FLASH and RECOVER without restarting
      if (state_q != StNormal) begin
         if (cnt_q == CW'(FLASH_HALF - 1)) begin
            cnt_d = '0;
            on_d  = ~on_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      unique case (state_q)
         StNormal: begin
            if (violation) begin
               code_d = {illegal, conflict};
               cnt_d  = '0;
               on_d   = 1'b1;
            end else begin
               for (int i = 0; i < 4; i++) lamp_d[i] = decode(cur[i]);
               prev_d     = cur;
               prev_vld_d = 1'b1;
            end
         end
         StFlash:   hold_d = '0;
         StRecover: begin
            if (!all_red) begin
               hold_d = '0;
            end else if (hold_done) begin
               hold_d     = '0;
               lamp_d     = {4{3'b100}};
               prev_d     = {4{RED}};
               prev_vld_d = 1'b1;
               code_d     = 2'b00;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lamp_q     <= {4{3'b100}};
         prev_q     <= {4{RED}};
         prev_vld_q <= 1'b0;
         code_q     <= 2'b00;
         cnt_q      <= '0;
         on_q       <= 1'b1;
         hold_q     <= '0;
      end else begin
         lamp_q     <= lamp_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         code_q     <= code_d;
         cnt_q      <= cnt_d;
         on_q       <= on_d;
         hold_q     <= hold_d;
      end
   end

   // Output logic
   always_comb begin
      fault      = (state_q != StNormal);
      flash      = (state_q != StNormal);
      fault_code = code_q;
      if (state_q == StNormal) begin
         {h1_lamp, h2_lamp, f1_lamp, f2_lamp} = lamp_q;
      end else begin
         h1_lamp = on_q ? 3'b010 : 3'b000;
         h2_lamp = h1_lamp;
         f1_lamp = h1_lamp;
         f2_lamp = h1_lamp;
      end
   end

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Bench for lamp_safety_monitor: directed scenarios then random traffic, all checked against a
// mode/time-based reference model.
module tb_lamp_safety_monitor;

   localparam int FH = 5;
   localparam int CH = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] h1, h2, f1, f2;
   logic       clr;
   logic [2:0] h1_lamp, h2_lamp, f1_lamp, f2_lamp;
   logic       fault;
   logic [1:0] fault_code;
   logic       flash;

   lamp_safety_monitor #(.FLASH_HALF(FH), .CLR_HOLD(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .h1        (h1),
      .h2        (h2),
      .f1        (f1),
      .f2        (f2),
      .clr       (clr),
      .h1_lamp   (h1_lamp),
      .h2_lamp   (h2_lamp),
      .f1_lamp   (f1_lamp),
      .f2_lamp   (f2_lamp),
      .fault     (fault),
      .fault_code(fault_code),
      .flash     (flash)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: mode 0 normal, 1 flash, 2 recover; m_t counts cycles since flash entry.
   int              mode = 0;
   logic [3:0][1:0] m_prev;
   bit              m_pvld = 0;
   int              m_t = 0;
   int              m_hold = 0;
   logic [1:0]      m_code = 2'b00;
   logic [3:0][2:0] m_lamp;
   logic [2:0]      dec_tbl [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

   task automatic model_edge(input logic [3:0][1:0] c, input logic cl, input logic r);
      bit all_red, conf, ill;
      all_red = (c == 8'hAA);
      if (r) begin
         mode   = 0;
         m_lamp = {4{3'b100}};
         m_pvld = 0;
         m_code = 2'b00;
         m_t    = 0;
         m_hold = 0;
         return;
      end
      case (mode)
         0: begin
            conf = (c[3] != 2'b10 || c[2] != 2'b10) && (c[1] != 2'b10 || c[0] != 2'b10);
            ill  = 0;
            if (m_pvld) begin
               for (int i = 0; i < 4; i++)
                  if (!(c[i] == m_prev[i] || c[i] == 2'(m_prev[i] + 2'd1))) ill = 1;
            end
            if (conf || ill) begin
               mode   = 1;
               m_code = {ill, conf};
               m_t    = 0;
            end else begin
               for (int i = 0; i < 4; i++) m_lamp[i] = dec_tbl[c[i]];
               m_prev = c;
               m_pvld = 1;
            end
         end
         1: begin
            m_t++;
            if (cl && all_red) begin
               mode   = 2;
               m_hold = 0;
            end
         end
         default: begin
            m_t++;
            if (all_red) begin
               m_hold++;
               if (m_hold == CH) begin
                  mode   = 0;
                  m_lamp = {4{3'b100}};
                  m_prev = 8'hAA;
                  m_pvld = 1;
                  m_code = 2'b00;
                  m_hold = 0;
               end
            end else begin
               mode   = 1;
               m_hold = 0;
            end
         end
      endcase
   endtask

   task automatic check(input string tag);
      logic [15:0] obs, exp;
      logic [2:0]  fl;
      fl  = ((m_t / FH) % 2 == 0) ? 3'b010 : 3'b000;
      exp = (mode == 0) ? {m_lamp, 1'b0, m_code, 1'b0} : {{4{fl}}, 1'b1, m_code, 1'b1};
      obs = {h1_lamp, h2_lamp, f1_lamp, f2_lamp, fault, fault_code, flash};
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [1:0] d, input logic cl, input logic r, input string tag);
      h1 = a; h2 = b; f1 = c; f2 = d; clr = cl; rst = r;
      @(posedge clk);
      model_edge({a, b, c, d}, cl, r);
      #1 check(tag);
   endtask

   initial begin
      logic [3:0][1:0] nc;
      logic            ncl, nr;

      // Reset state and first sample after reset
      step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, "reset");
      expect3("reset_lamp", h1_lamp, 3'b100);
      step(2'b00, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "first_sample");
      expect3("first_sample_lamp", h1_lamp, 3'b001);
      expect3("first_sample_fault", {2'b00, fault}, 3'b000);

      // Legal highway cycle
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, "reset2");
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "cyc_red");
      step(2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, "cyc_ry");
      expect3("cyc_ry_lamp", h2_lamp, 3'b110);
      step(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, "cyc_green");
      step(2'b01, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, "cyc_yellow");
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "cyc_red2");

      // Conflict on first sample, then a full blink period
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, "reset3");
      step(2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, "conflict");
      expect3("conflict_code", {1'b0, fault_code}, 3'b001);
      for (int i = 0; i < 9; i++) step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "blink");
      expect3("blink_off", f2_lamp, 3'b000);

      // Clear: ignored with f2 green, then accepted and held red
      step(2'b10, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, "clr_ignored");
      expect3("clr_ignored_flash", {2'b00, flash}, 3'b001);
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0, "clr_accept");
      for (int i = 0; i < CH; i++) step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "hold_red");
      expect3("cleared_lamp", f1_lamp, 3'b100);

      // Illegal transition on h2, then abort in recover
      step(2'b10, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, "h2_ry");
      step(2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, "h2_green");
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "h2_illegal");
      expect3("illegal_code", {1'b0, fault_code}, 3'b010);
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0, "clr2");
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "rec_red1");
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "rec_red2");
      step(2'b10, 2'b10, 2'b11, 2'b10, 1'b0, 1'b0, "rec_abort");
      expect3("abort_code", {flash, fault_code}, 3'b110);
      step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, "flash_hold");
      step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, "rst_mid_flash");
      expect3("rst_mid_flash_lamp", h2_lamp, 3'b100);

      // Conflict plus illegal transition together
      step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "prime_red");
      step(2'b00, 2'b10, 2'b11, 2'b10, 1'b0, 1'b0, "both");
      expect3("both_code", {1'b0, fault_code}, 3'b011);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         nc  = {h1, h2, f1, f2};
         nr  = ($urandom_range(0, 149) == 0);
         ncl = 1'b0;
         if (mode == 0) begin
            for (int i = 0; i < 4; i++)
               if ($urandom_range(0, 3) == 0) nc[i] = 2'(nc[i] + 2'd1);
            if ($urandom_range(0, 19) == 0) nc[$urandom_range(0, 3)] = 2'($urandom);
            ncl = ($urandom_range(0, 9) == 0);
         end else begin
            nc  = ($urandom_range(0, 99) < 85) ? 8'hAA : 8'($urandom);
            ncl = $urandom_range(0, 1) == 1;
         end
         step(nc[3], nc[2], nc[1], nc[0], ncl, nr, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lamp_safety_monitor.md
LAMP_SAFETY_MONITOR -- requirements
Module: lamp_safety_monitor

Interface
REQ-001 SHALL have parameter FLASH_HALF, default 5: cycles per half-period of the fault flash.
REQ-002 SHALL have parameter CLR_HOLD, default 3: consecutive all-red cycles required before leaving fault.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports h1, h2, f1, f2, input, 2 bits each: signal codes from the traffic light controller (00 green, 01 yellow, 10 red, 11 red+yellow).
REQ-006 SHALL have port clr, input, 1 bit: fault-clear request.
REQ-007 SHALL have ports h1_lamp, h2_lamp, f1_lamp, f2_lamp, output, 3 bits each: {R,Y,G} lamp drives.
REQ-008 SHALL have port fault, output, 1 bit: latched safety fault.
REQ-009 SHALL have port fault_code, output, 2 bits: bit0 conflict, bit1 illegal transition.
REQ-010 SHALL have port flash, output, 1 bit: 1 while lamps are in flash mode.

Function
REQ-011 SHALL decode codes in NORMAL: 00->001, 01->010, 10->100, 11->110, registered, 1-cycle latency from input sample to lamp output.
REQ-012 SHALL implement states NORMAL, FLASH and RECOVER.
REQ-013 SHALL register the previous sample of all four codes plus a prev_vld flag; prev_vld SHALL be 0 after reset and 1 after the first NORMAL sample.
REQ-014 SHALL flag a conflict when any highway code != 10 and any farm code != 10 in the same sample.
REQ-015 SHALL flag an illegal transition when prev_vld=1 and any channel changes other than 10->11, 11->00, 00->01 or 01->10; an unchanged code is legal.
REQ-016 SHALL, on a conflict or illegal transition sampled in NORMAL, go to FLASH at that same edge, setting fault=1, flash=1 and fault_code from that sample; both conditions together give 11.
REQ-017 SHALL hold fault_code unchanged while in FLASH or RECOVER; later violations SHALL be ignored.
REQ-018 SHALL, in FLASH and RECOVER, drive all four lamps to 010 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating; the phase SHALL start "on" with the counter at 0 on FLASH entry.
REQ-019 SHALL go from FLASH to RECOVER when clr=1 and all four codes are 10 in the same sample; otherwise clr SHALL be ignored.
REQ-020 SHALL, in RECOVER, count consecutive all-red samples; on reaching CLR_HOLD it SHALL enter NORMAL, with fault=0, fault_code=00, flash=0, all lamps 100, prev set to 10 on all channels, and prev_vld=1.
REQ-021 SHALL, in RECOVER, return to FLASH on any non-red sample, resetting the hold count; the blink phase SHALL continue uninterrupted.
REQ-022 SHALL ignore clr in NORMAL and in RECOVER.
REQ-023 SHALL use a blink counter of width clog2(FLASH_HALF)+1, wrapping to 0 at FLASH_HALF-1.

Reset
REQ-024 SHALL, while rst=1 at a rising edge, set state NORMAL, all lamps 100, fault=0, fault_code=00, flash=0, prev_vld=0, hold count 0, blink counter 0.
REQ-025 SHALL give rst priority over every other input, including mid-FLASH and mid-RECOVER; no input is checked on a reset edge.

Verification
REQ-026 SHALL cover the legal cycle: h1=h2: 10->11->00->01->10, with farm held at 10 -> lamps 100,110,001,010,100, each one cycle late; fault stays 0.
REQ-027 SHALL cover a conflict: h1=00 and f1=00 sampled together -> at that edge fault=1, fault_code=01, flash=1; lamps 010 for 5 cycles, then 000 for 5 cycles.
REQ-028 SHALL cover an illegal transition: h2 changing 00->10 -> fault_code=10; a combined conflict and illegal transition -> fault_code=11.
REQ-029 SHALL cover clearing: clr=1 with all codes 10, held red for 3 cycles -> NORMAL, fault=0, lamps 100; clr with f2=00 -> ignored, FLASH is kept.
REQ-030 SHALL cover an abort in RECOVER: f1=11 after 2 red cycles -> back to FLASH with fault_code unchanged; rst=1 mid-FLASH -> all lamps 100, fault=0 on the next edge.
REQ-031 SHALL cover the first sample after reset: h1=00 with prev_vld=0 -> no illegal-transition fault, lamp 001.
